// File: rtl/tt_bist_harness.sv
// LFSR-driven BIST wrapper for a tt_um_* project: stimulates its pins and compacts responses in a MISR.
// Define TT_BIST_TRACE_EN to enable the per-capture trace strobe; otherwise trace_* are tied to 0.
module tt_bist_harness #(
    parameter int unsigned IO_W        = 8,
    parameter int unsigned NUM_VECTORS = 256,
    parameter int unsigned SETTLE      = 2,
    parameter int unsigned RST_CYCLES  = 4,
    parameter logic [2*IO_W-1:0] LFSR_POLY = (2*IO_W)'('hB400),
    parameter logic [2*IO_W-1:0] LFSR_SEED = (2*IO_W)'('h0001),
    parameter logic [2*IO_W-1:0] MISR_POLY = (2*IO_W)'('h1021),
    parameter logic [2*IO_W-1:0] EXP_SIG   = (2*IO_W)'('h0000),
    localparam int unsigned VCW = $clog2(NUM_VECTORS + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [2*IO_W-1:0] signature,
    output logic [VCW-1:0]  vec_count,
    output logic [IO_W-1:0] dut_ui_in,
    output logic [IO_W-1:0] dut_uio_in,
    output logic            dut_ena,
    output logic            dut_rst_n,
    input  logic [IO_W-1:0] dut_uo_out,
    input  logic [IO_W-1:0] dut_uio_out,
    input  logic [IO_W-1:0] dut_uio_oe,
    output logic            trace_vld,
    output logic [2*IO_W-1:0] trace_data
);

    localparam int unsigned W2      = 2 * IO_W;
    localparam int unsigned MAX_CNT = (RST_CYCLES > SETTLE) ? RST_CYCLES : SETTLE;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
    // An all-zero seed would lock the LFSR at zero.
    localparam logic [W2-1:0] SEED  = (LFSR_SEED == '0) ? W2'(1) : LFSR_SEED;

    typedef enum logic [2:0] {
        StIdle,
        StRstDut,
        StApply,
        StSettle,
        StCapture,
        StDone
    } state_t;

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W2-1:0]   lfsr_q, lfsr_d;
    logic [W2-1:0]   sig_q, sig_d;
    logic [VCW-1:0]  vec_q, vec_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic            ena_q, ena_d;
    logic            rst_n_q, rst_n_d;
    logic [IO_W-1:0] ui_q, ui_d;
    logic [IO_W-1:0] uio_q, uio_d;

    logic [W2-1:0]   resp;
    logic [W2-1:0]   sig_fold;
    logic [W2-1:0]   lfsr_step;

    assign resp      = {dut_uio_out & dut_uio_oe, dut_uo_out};
    assign sig_fold  = {sig_q[W2-2:0], 1'b0} ^ (sig_q[W2-1] ? MISR_POLY : '0) ^ resp;
    assign lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_POLY : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            lfsr_q  <= SEED;
            sig_q   <= '0;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            ena_q   <= 1'b0;
            rst_n_q <= 1'b0;
            ui_q    <= '0;
            uio_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            sig_q   <= sig_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            ena_q   <= ena_d;
            rst_n_q <= rst_n_d;
            ui_q    <= ui_d;
            uio_q   <= uio_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lfsr_d  = lfsr_q;
        sig_d   = sig_q;
        vec_d   = vec_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        ena_d   = ena_q;
        rst_n_d = rst_n_q;
        ui_d    = ui_q;
        uio_d   = uio_q;

        if (abort) begin
            // Signature and vec_count are left untouched for post-mortem inspection.
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            ena_d   = 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (state_q == StDone) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                        pass_d = (sig_q == EXP_SIG);
                    end
                    if (start) begin
                        // Reseed so every run replays the same vector sequence.
                        state_d = StRstDut;
                        cnt_d   = '0;
                        lfsr_d  = SEED;
                        sig_d   = '0;
                        vec_d   = '0;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                        pass_d  = 1'b0;
                        ena_d   = 1'b1;
                        rst_n_d = 1'b0;
                    end
                end
                StRstDut: begin
                    if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                        cnt_d   = '0;
                        rst_n_d = 1'b1;
                        state_d = StApply;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StApply: begin
                    ui_d    = lfsr_q[IO_W-1:0];
                    uio_d   = lfsr_q[W2-1:IO_W];
                    cnt_d   = '0;
                    state_d = (SETTLE == 0) ? StCapture : StSettle;
                end
                StSettle: begin
                    if (cnt_q == CNT_W'(SETTLE - 1)) begin
                        cnt_d   = '0;
                        state_d = StCapture;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StCapture: begin
                    sig_d   = sig_fold;
                    lfsr_d  = lfsr_step;
                    vec_d   = vec_q + VCW'(1);
                    state_d = (vec_q == VCW'(NUM_VECTORS - 1)) ? StDone : StApply;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign signature  = sig_q;
    assign vec_count  = vec_q;
    assign dut_ui_in  = ui_q;
    assign dut_uio_in = uio_q;
    assign dut_ena    = ena_q;
    assign dut_rst_n  = rst_n_q;

`ifdef TT_BIST_TRACE_EN
    logic          capture_fire;
    logic          trace_vld_q;
    logic [W2-1:0] trace_data_q;

    assign capture_fire = (state_q == StCapture) && !abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            trace_vld_q  <= 1'b0;
            trace_data_q <= '0;
        end else begin
            trace_vld_q <= capture_fire;
            if (capture_fire) begin
                trace_data_q <= resp;
            end
        end
    end

    assign trace_vld  = trace_vld_q;
    assign trace_data = trace_data_q;
`else
    assign trace_vld  = 1'b0;
    assign trace_data = '0;
`endif

endmodule
